// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave holding one WIDTH-bit register, served by PUT/GET frames.
// Everything runs on clk; SPI pins are oversampled through synchronizer chains.
module spi_reg_slave #(
    parameter int WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             SDO,
    input  logic             CS_n,
    output logic             SDI,
    output logic [WIDTH-1:0] d,
    output logic             wr_strobe,
    output logic             rd_strobe,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DONE} state_t;

    // Pin bundle bit order: [0]=SCLK, [1]=SDO, [2]=CS_n
    logic [2:0]                    pins;
    logic [SYNC_STAGES-1:0][2:0]   sync_reg;
    logic [2:0]                    dly_reg;

    logic             sclk_rise, sclk_fall, cs_rise, cs_fall, sdo_s;
    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] d_reg;
    logic             sdi_reg, wr_strobe_reg, rd_strobe_reg, busy_reg;

    assign pins = {CS_n, SDO, SCLK};

    // Synchronizers clear to 0 so a CS_n held low across reset exit yields no falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            dly_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pins};
            dly_reg  <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sclk_rise  = sync_reg[SYNC_STAGES-1][0] & ~dly_reg[0];
    assign sclk_fall  = ~sync_reg[SYNC_STAGES-1][0] & dly_reg[0];
    assign sdo_s      = sync_reg[SYNC_STAGES-1][1];
    assign cs_rise    = sync_reg[SYNC_STAGES-1][2] & ~dly_reg[2];
    assign cs_fall    = ~sync_reg[SYNC_STAGES-1][2] & dly_reg[2];
    assign shift_next = {shift_reg[WIDTH-2:0], sdo_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            d_reg         <= RESET_VAL;
            sdi_reg       <= 1'b0;
            wr_strobe_reg <= 1'b0;
            rd_strobe_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            wr_strobe_reg <= 1'b0;
            rd_strobe_reg <= 1'b0;
            if (cs_rise) begin
                // Frame aborted or finished; any coincident SCLK edge is dropped
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                sdi_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (cs_fall) begin
                            state_reg <= CMD;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            if (sdo_s) begin
                                state_reg <= WRITE;
                                shift_reg <= '0;
                            end else begin
                                state_reg <= READ;
                                shift_reg <= d_reg;
                            end
                        end
                    end
                    WRITE: begin
                        if (sclk_rise) begin
                            shift_reg <= shift_next;
                            cnt_reg   <= cnt_reg + CW'(1);
                            if (cnt_reg == CW'(WIDTH - 1)) begin
                                d_reg         <= shift_next;
                                wr_strobe_reg <= 1'b1;
                                state_reg     <= DONE;
                            end
                        end
                    end
                    READ: begin
                        if (sclk_fall) begin
                            sdi_reg   <= shift_reg[WIDTH-1];
                            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            cnt_reg <= cnt_reg + CW'(1);
                            if (cnt_reg == CW'(WIDTH - 1)) begin
                                rd_strobe_reg <= 1'b1;
                                sdi_reg       <= 1'b0;
                                state_reg     <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        sdi_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        sdi_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SDI       = sdi_reg;
    assign d         = d_reg;
    assign wr_strobe = wr_strobe_reg;
    assign rd_strobe = rd_strobe_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a behavioural SPI master issues PUT/GET frames.
module tb_spi_reg_slave;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCLK = 1'b0;
    logic        SDO = 1'b0;
    logic        CS_n = 1'b1;
    logic        SDI;
    logic [15:0] d;
    logic        wr_strobe, rd_strobe, busy;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int sdi_nz = 0;
    bit in_put = 1'b0;

    spi_reg_slave #(.WIDTH(16), .RESET_VAL(16'h0000), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .SDO(SDO), .CS_n(CS_n),
        .SDI(SDI), .d(d), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (rd_strobe) rd_cnt++;
        if (in_put && SDI) sdi_nz++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic s);
        SDO = b;
        wait_clk(HALF);
        s = SDI;
        SCLK = 1'b1;
        wait_clk(HALF);
        SCLK = 1'b0;
    endtask

    // cmd bit, nbits data bits (MSB first), extra SCLK pulses, then CS_n high for 3 clk
    task automatic spi_frame(input logic cmd, input logic [15:0] data, input int nbits,
                             input int extra, output logic [15:0] rdata);
        logic s;
        rdata = '0;
        CS_n = 1'b0;
        wait_clk(HALF);
        spi_bit(cmd, s);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(data[15-i], s);
            rdata = {rdata[14:0], s};
        end
        for (int i = 0; i < extra; i++) spi_bit(1'b1, s);
        wait_clk(HALF);
        CS_n = 1'b1;
        SDO = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL reset_d: got %h want 0000", d); end
        vectors++; if (SDI !== 1'b0) begin miscompares++; $display("FAIL reset_sdi: got %b want 0", SDI); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (wr_cnt !== 0 || rd_cnt !== 0) begin miscompares++; $display("FAIL reset_strobes: got wr=%0d rd=%0d want 0/0", wr_cnt, rd_cnt); end
        $display("reset: d=%h busy=%b SDI=%b", d, busy, SDI);
    endtask

    task automatic test_put;
        logic [15:0] r;
        int w0 = wr_cnt;
        int n0 = sdi_nz;
        in_put = 1'b1;
        spi_frame(1'b1, 16'hA5C3, 16, 0, r);
        in_put = 1'b0;
        vectors++; if (d !== 16'hA5C3) begin miscompares++; $display("FAIL put_d: got %h want a5c3", d); end
        vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL put_wr_strobe: got %0d pulses want 1", wr_cnt - w0); end
        vectors++; if (sdi_nz - n0 !== 0) begin miscompares++; $display("FAIL put_sdi_quiet: got %0d high clks want 0", sdi_nz - n0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL put_busy_end: got %b want 0", busy); end
        $display("PUT a5c3: d=%h wr_pulses=%0d", d, wr_cnt - w0);
    endtask

    task automatic test_get;
        logic [15:0] r;
        int r0 = rd_cnt;
        int w0 = wr_cnt;
        spi_frame(1'b0, 16'h0000, 16, 0, r);
        vectors++; if (r !== 16'hA5C3) begin miscompares++; $display("FAIL get_data: got %h want a5c3", r); end
        vectors++; if (rd_cnt - r0 !== 1) begin miscompares++; $display("FAIL get_rd_strobe: got %0d pulses want 1", rd_cnt - r0); end
        vectors++; if (d !== 16'hA5C3) begin miscompares++; $display("FAIL get_d_kept: got %h want a5c3", d); end
        vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL get_no_wr: got %0d pulses want 0", wr_cnt - w0); end
        $display("GET: read=%h rd_pulses=%0d", r, rd_cnt - r0);
    endtask

    task automatic test_partial_put;
        logic [15:0] r;
        int w0 = wr_cnt;
        spi_frame(1'b1, 16'hFFFF, 8, 0, r);
        wait_clk(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL partial_busy: got %b want 0", busy); end
        vectors++; if (d !== 16'hA5C3) begin miscompares++; $display("FAIL partial_d: got %h want a5c3", d); end
        vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL partial_wr: got %0d pulses want 0", wr_cnt - w0); end
        $display("partial PUT ffff: d=%h busy=%b", d, busy);
    endtask

    task automatic test_reset_mid_get;
        logic s;
        logic [15:0] r;
        int r0 = rd_cnt;
        CS_n = 1'b0;
        wait_clk(HALF);
        spi_bit(1'b0, s);
        wait_clk(4);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midget_busy: got %b want 1", busy); end
        vectors++; if (SDI !== 1'b1) begin miscompares++; $display("FAIL midget_first_bit: got %b want 1", SDI); end
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL midrst_d: got %h want 0000", d); end
        vectors++; if (SDI !== 1'b0) begin miscompares++; $display("FAIL midrst_sdi: got %b want 0", SDI); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        wait_clk(6);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_cs_low_exit: got busy=%b want 0", busy); end
        CS_n = 1'b1;
        wait_clk(5);
        spi_frame(1'b0, 16'h0000, 16, 0, r);
        vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL midrst_get: got %h want 0000", r); end
        vectors++; if (rd_cnt - r0 !== 1) begin miscompares++; $display("FAIL midrst_rd_strobe: got %0d pulses want 1", rd_cnt - r0); end
        $display("reset mid-GET: d=%h next GET=%h", d, r);
    endtask

    task automatic test_extra_pulses;
        logic [15:0] r;
        int w0 = wr_cnt;
        spi_frame(1'b1, 16'h1234, 16, 4, r);
        vectors++; if (d !== 16'h1234) begin miscompares++; $display("FAIL extra_d: got %h want 1234", d); end
        vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL extra_wr: got %0d pulses want 1", wr_cnt - w0); end
        $display("PUT 1234 + 4 extra pulses: d=%h wr_pulses=%0d", d, wr_cnt - w0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] last_put = 16'h1234;
        logic [15:0] v, r;
        logic is_put;
        for (int i = 0; i < 12; i++) begin
            is_put = (i % 3 != 2) ? $urandom_range(0, 1) : 1'b0;
            v = $urandom_range(0, 16'hFFFF);
            spi_frame(is_put, v, 16, 0, r);
            if (is_put) begin
                last_put = v;
                vectors++; if (d !== last_put) begin miscompares++; $display("FAIL b2b_put_%0d: got %h want %h", i, d, last_put); end
                $display("b2b %0d PUT %h: d=%h", i, v, d);
            end else begin
                vectors++; if (r !== last_put) begin miscompares++; $display("FAIL b2b_get_%0d: got %h want %h", i, r, last_put); end
                $display("b2b %0d GET: read=%h", i, r);
            end
        end
    endtask

    initial begin
        test_reset;
        test_put;
        test_get;
        test_partial_put;
        test_reset_mid_get;
        test_extra_pulses;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
